// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the multi-cycle data-memory
// responder.
//   state_t        - responder FSM states (IDLE, WAIT, RESP)
//   BYTE_OFF_W     - width of the byte-offset field of a byte address
//   IDX_LSB        - lowest address bit of the word index
//   MISALIGN_MASK  - byte-offset bits that must be zero for a word access
//   is_misaligned  - true when a byte offset is not word aligned
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int BYTE_OFF_W = 2;
  localparam int IDX_LSB    = 2;

  localparam logic [BYTE_OFF_W-1:0] MISALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [BYTE_OFF_W-1:0] byte_off);
    return (byte_off & MISALIGN_MASK) != '0;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage load/store port between the CPU (master) and
// the data-memory responder (slave).
//
// Handshake rules: a transfer happens on a rising clk edge where valid and
// ready are both high. The request side (req_valid/req_ready) carries
// req_addr, req_write and req_wdata; they are sampled only on that edge. The
// response side (resp_valid/resp_ready) carries resp_rdata and resp_err, which
// the responder holds stable from resp_valid rising until the transfer edge.
// busy is high while a request is in flight or a response is unconsumed.
interface dmem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              busy;

  modport master (
    output req_valid, req_addr, req_write, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );

endinterface

// File: rtl/dmem_latency_counter.sv
// dmem_latency_counter: load/decrement down-counter that times the access
// latency of the responder.
//   clk, reset - clock and synchronous active-high reset
//   load       - load LATENCY-1 (request accepted)
//   dec        - count down by one while non-zero
//   expired    - counter is zero
module dmem_latency_counter #(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam int CNT_W = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word-addressed data memory answering one
// MEM-stage request at a time with a fixed access latency.
//   clk, reset - clock (rising edge) and synchronous active-high reset
//   bus        - dmem_responder_if slave port (request, response, busy)
//   dbg_state  - current FSM state
// A request accepted at edge E0 produces resp_valid after edge E0+LATENCY;
// the response is held until the CPU takes it, then the block returns to
// IDLE, so the next request can be accepted one edge after the handshake.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 16384,
  parameter int LATENCY     = 4
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus,
  output state_t          dbg_state
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // Only the index and byte-offset bits are kept; higher bits wrap away.
  localparam int USED_W = IDX_W + IDX_LSB;

  state_t state, state_nxt;

  logic accept;
  logic access;
  logic handshake;
  logic expired;
  logic req_ready_c;
  logic resp_valid_c;
  logic busy_c;

  logic [USED_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  // Array storage carries no reset so it can map onto RAM; word_vld marks
  // words written since reset, and unwritten words read back as zero.
  logic [DATA_W-1:0]      mem [DEPTH_WORDS];
  logic [DEPTH_WORDS-1:0] word_vld;

  logic [IDX_W-1:0] idx;
  logic             misaligned;
  logic             commit;
  logic             addr_hi_unused;

  assign idx        = addr_q[USED_W-1:IDX_LSB];
  assign misaligned = is_misaligned(addr_q[BYTE_OFF_W-1:0]);
  // Reset on the access edge aborts the store before it lands.
  assign commit     = access && write_q && !misaligned && !reset;

  assign addr_hi_unused = ^bus.req_addr[ADDR_W-1:USED_W];

  dmem_latency_counter #(
    .LATENCY(LATENCY)
  ) u_lat (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .dec    (state == WAIT),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    access       = 1'b0;
    handshake    = 1'b0;
    req_ready_c  = 1'b0;
    resp_valid_c = 1'b0;
    busy_c       = 1'b1;
    case (state)
      IDLE: begin
        req_ready_c = 1'b1;
        busy_c      = 1'b0;
        if (bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (expired) begin
          access    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid_c = 1'b1;
        if (bus.resp_ready) begin
          handshake = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= bus.req_addr[USED_W-1:0];
      write_q <= bus.req_write;
      wdata_q <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (access) begin
      if (misaligned) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end else if (write_q) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end else begin
        rdata_q <= word_vld[idx] ? mem[idx] : '0;
        err_q   <= 1'b0;
      end
    end else if (handshake) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[idx] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_vld <= '0;
    end else if (commit) begin
      word_vld[idx] <= 1'b1;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_c;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.busy       = busy_c;
  assign dbg_state      = state;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 16;
  localparam int LAT   = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  dmem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();
  state_t dbg1, dbg2;

  dmem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbg_state(dbg1)
  );

  dmem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_lat1 (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus2),
    .dbg_state(dbg2)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [DW:0]   exp_q[$];   // {err, rdata}
  int            due_q[$];   // edge count at which resp_valid must be seen
  logic [DW-1:0] model_mem [DEPTH];
  bit            rand_rr = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event did not occur within bound (edge %0d)", name, cyc);
  endtask

  // Reference model: plain word array, index wraps modulo DEPTH.
  task automatic model_push(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    int idx;
    idx = int'((a >> 2) % DEPTH);
    if (a[1:0] != 2'b00) begin
      exp_q.push_back({1'b1, {DW{1'b0}}});
    end else if (w) begin
      model_mem[idx] = d;
      exp_q.push_back({1'b0, {DW{1'b0}}});
    end else begin
      exp_q.push_back({1'b0, model_mem[idx]});
    end
    due_q.push_back(cyc + LAT);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                        input bit with_hs, output int hs_edge, output int acc_edge);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    hs_edge = cyc + 1;
    if (with_hs) bus.resp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_write = w;
    bus.req_wdata = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_now("accept_timeout");
      bus.req_valid = 1'b0;
      acc_edge = -1;
      return;
    end
    @(posedge clk); #1;
    acc_edge = cyc;
    model_push(a, w, d);
    bus.req_valid = 1'b0;
    // Scramble the request fields: they must not matter after acceptance.
    bus.req_addr  = $urandom;
    bus.req_write = 1'($urandom_range(0, 1));
    bus.req_wdata = $urandom;
  endtask

  task automatic req(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    int h, e;
    do_req(a, w, d, 1'b0, h, e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.busy) return;
    end
    fail_now("wait_idle");
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    due_q.delete();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'(1));
    check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_rdata", 64'(bus.resp_rdata), 64'(0));
    check("rst_err", 64'(bus.resp_err), 64'(0));
    check("rst_state", 64'(dbg1), 64'(IDLE));
  endtask

  // ---------------- random consumer ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rr) bus.resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor ----------------
  bit            in_resp = 1'b0;
  bit            hs_prev = 1'b0;
  logic [DW:0]   held;

  always @(negedge clk) begin
    if (reset) begin
      in_resp = 1'b0;
      hs_prev = 1'b0;
    end else begin
      logic [DW:0] cur;
      int          due;
      bit          exp_busy;
      if (hs_prev) begin
        check("hs_clear_valid", 64'(bus.resp_valid), 64'(0));
        check("hs_clear_rdata", 64'(bus.resp_rdata), 64'(0));
        check("hs_clear_err", 64'(bus.resp_err), 64'(0));
      end
      if (bus.resp_valid && !in_resp) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_resp_valid");
        end else begin
          cur = exp_q.pop_front();
          due = due_q.pop_front();
          check("resp_rdata", 64'(bus.resp_rdata), 64'(cur[DW-1:0]));
          check("resp_err", 64'(bus.resp_err), 64'(cur[DW]));
          check("latency", 64'(cyc), 64'(due));
        end
        in_resp = 1'b1;
        held    = {bus.resp_err, bus.resp_rdata};
      end else if (bus.resp_valid) begin
        check("resp_hold", 64'({bus.resp_err, bus.resp_rdata}), 64'(held));
      end
      if (!bus.resp_valid) in_resp = 1'b0;
      if (!bus.resp_valid && due_q.size() > 0 && cyc > due_q[0]) begin
        fail_now("resp_late");
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      exp_busy = bus.resp_valid || (exp_q.size() > 0);
      check("busy", 64'(bus.busy), 64'(exp_busy));
      check("req_ready", 64'(bus.req_ready), 64'(!exp_busy));
      hs_prev = bus.resp_valid && bus.resp_ready;
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    int h, e, e0, first_v, last_v, n;
    bit ok;

    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_write  = 1'b0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    bus2.req_valid  = 1'b0;
    bus2.req_addr   = '0;
    bus2.req_write  = 1'b0;
    bus2.req_wdata  = '0;
    bus2.resp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state();

    // Read of a cleared word, store then load back.
    req(32'h40, 1'b0, '0);
    req(32'h100, 1'b1, 32'hDEAD_BEEF);
    req(32'h100, 1'b0, '0);
    wait_idle();

    // Stalled consumer, then a request held through the handshake cycle.
    rand_rr = 1'b0;
    @(posedge clk); #2;
    bus.resp_ready = 1'b0;
    req(32'h100, 1'b0, '0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("stall_resp_valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(bus.resp_valid), 64'(1));
      check("stall_rdata", 64'(bus.resp_rdata), 64'(32'hDEAD_BEEF));
    end
    do_req(32'h104, 1'b0, '0, 1'b1, h, e);
    check("accept_after_hs", 64'(e), 64'(h + 1));
    rand_rr = 1'b1;
    wait_idle();

    // Misaligned store must not write; wrap of the word index.
    req(32'h42, 1'b1, 32'h1234);
    req(32'h40, 1'b0, '0);
    req(32'h44, 1'b1, 32'h5555);
    req(32'h04, 1'b0, '0);
    req(32'h03, 1'b0, '0);

    // Randomized traffic across four wraps of the array.
    for (int i = 0; i < 150; i++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      req(a, 1'($urandom_range(0, 1)), $urandom);
    end
    wait_idle();

    // Reset two edges after accepting a store: the store never lands.
    req(32'h8, 1'b1, 32'hAAAA_AAAA);
    do_reset(1);
    check_reset_state();
    req(32'h8, 1'b0, '0);
    req(32'h100, 1'b0, '0);
    wait_idle();

    // LATENCY=1 instance: req_valid and resp_ready tied high.
    do_reset(1);
    bus2.req_valid  = 1'b1;
    bus2.resp_ready = 1'b1;
    e0 = -1; first_v = -1; last_v = -1; n = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (e0 < 0 && bus2.req_ready) e0 = cyc + 1;
      if (bus2.resp_valid) begin
        n++;
        check("lat1_rdata", 64'(bus2.resp_rdata), 64'(0));
        if (n == 1) first_v = cyc;
        if (n == 10) begin
          last_v = cyc;
          break;
        end
      end
    end
    bus2.req_valid = 1'b0;
    check("lat1_count", 64'(n), 64'(10));
    check("lat1_first", 64'(first_v), 64'(e0 + 1));
    // Ten requests at three cycles each: last handshake on edge e0+29.
    check("lat1_tenth", 64'(last_v), 64'(e0 + 28));

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete by edge %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder that sits on the far side of the pipelined CPU's MEM-stage load/store port.
- The CPU's MEM stage is the initiator: it issues one request at a time and stalls the pipeline until the response arrives.
- This block accepts the request, models a fixed access latency, performs the word read or write on its internal array, and holds the response until the CPU takes it.
- It replaces the single-cycle data memory whenever MEM-stage stall and hazard logic is being exercised.

Parameters:
- DATA_W, 32, data word width in bits.
- ADDR_W, 32, byte-address width.
- DEPTH_WORDS, 16384, number of words in the array; must be a power of two. IDX_W = log2(DEPTH_WORDS).
- LATENCY, 4, edges from request acceptance to response; must be ≥ 1.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  CPU presents a request
- req_ready  out  1  responder can accept a request
- req_addr  in  ADDR_W  byte address
- req_write  in  1  1 = store, 0 = load
- req_wdata  in  DATA_W  store data
- resp_valid  out  1  response available
- resp_ready  in  1  CPU consumes the response
- resp_rdata  out  DATA_W  load data; 0 for stores and errors
- resp_err  out  1  request was misaligned
- busy  out  1  a request is in flight or a response is unconsumed

Behaviour:
- Reset:
  - reset is synchronous, active-high; clock is clk.
  - State goes to IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; busy=0.
  - All array words are cleared to 0.
  - Reset mid-operation aborts the in-flight request. A store not yet committed is never written.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1, busy=0.
  - On an edge with req_valid=1, latch addr, write and wdata; load cnt=LATENCY-1; go to WAIT.
- WAIT:
  - req_ready=0, busy=1.
  - If cnt≠0: cnt decrements.
  - If cnt==0: perform the access (below), drive the response registers, go to RESP.
- RESP:
  - resp_valid=1, busy=1, req_ready=0.
  - resp_rdata and resp_err are held stable until the handshake.
  - On an edge with resp_ready=1: resp_valid→0, resp_rdata→0, resp_err→0, go to IDLE.
- Latency:
  - Request accepted at edge E0 → resp_valid high after edge E0+LATENCY.
  - Earliest next acceptance is the edge after the response handshake, so back-to-back throughput is one request per LATENCY+2 cycles.
  - A req_valid arriving in the same cycle as the resp_ready handshake is not accepted; it must be held into IDLE.
- Access:
  - Word index = latched addr[IDX_W+1:2]. Address bits above the index are ignored, so addresses wrap modulo DEPTH_WORDS×4.
  - Load: resp_rdata = array[index].
  - Store: array[index] = wdata, committed at the access edge; resp_rdata = 0.
- Misaligned (addr[1:0]≠0):
  - No array access and no write.
  - Full latency is still observed.
  - resp_err=1, resp_rdata=0.
- Protocol:
  - req_addr/req_write/req_wdata are sampled only at the acceptance edge; changes afterwards are ignored.
  - resp_ready is ignored outside RESP.
- Simultaneous events: reset overrides everything, including a concurrent handshake.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE, WAIT, RESP}
  - address-split constants: byte-offset width 2, index LSB 2
  - MISALIGN_MASK = 2'b11
- Sub-module dmem_latency_counter:
  - load/decrement down-counter of width log2(LATENCY)+1
  - outputs expired (cnt==0)
- Array and FSM remain in dmem_responder.

Test Plan:
- Reset: after reset → req_ready=1, resp_valid=0, busy=0. Load addr 0x40 → resp_rdata=0x0000_0000 after 4 edges.
- Store then load: store 0xDEAD_BEEF to 0x100, accept and handshake; load 0x100 → resp_valid rises exactly 4 edges after acceptance, resp_rdata=0xDEAD_BEEF, resp_err=0.
- Stalled consumer: load 0x100 with resp_ready=0 for 5 cycles → resp_valid and resp_rdata=0xDEAD_BEEF held stable. resp_ready=1 → IDLE next edge; a req_valid held during the handshake cycle is accepted on the following edge.
- Misaligned and wrap, DEPTH_WORDS=16:
  - Store 0x1234 to 0x42 → resp_err=1 and no write.
  - Store 0x5555 to 0x44 → then load 0x04 returns 0x5555 (wrap).
- Reset mid-op: store 0xAAAA_AAAA to 0x8, assert reset 2 edges after acceptance → after reset, load 0x8 returns 0 and resp_valid was never asserted.
- LATENCY=1 build: load accepted at edge E0 → resp_valid after E0+1. Ten back-to-back requests with resp_ready tied 1 complete in 30 cycles.
